board_fetch_arbiter: RTL and testbench

Shares the single-port Tetris board RAM (10×20 cells, 3-bit colour code per cell) between the video path and the game logic. During each horizontal blanking interval preceding a new cell row it prefetches that row into a 10-entry line buffer. From the buffer it supplies a per-pixel cell colour for the current DrawX/DrawY. Game-logic reads and writes are granted only when the video prefetch does not need the RAM. It sits between the VGA timing generator (DrawX/DrawY) and the colour mapper.

---
 rtl/tetris_board_pkg.sv | 14 +
 rtl/board_line_buf.sv | 22 ++
 rtl/board_fetch_arbiter.sv | 129 ++++++++++++
 tb/tb_board_fetch_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_board_pkg.sv
// tetris_board_pkg: board geometry, arbiter FSM states and the cell address helper
package tetris_board_pkg;
    localparam int COLS       = 10;
    localparam int ROWS       = 20;
    localparam int COLOR_W    = 3;
    localparam int ADDR_W     = 8;
    localparam int CELL_SHIFT = 4;

    typedef enum logic [1:0] {IDLE, FETCH, FETCH_LAST, GAME_ACK} state_t;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row, input logic [3:0] col);
        return ADDR_W'(int'(row) * COLS + int'(col));
    endfunction
endpackage

// File: rtl/board_line_buf.sv
// board_line_buf: one board row of cell colours, sync clear, one write port, comb read port
// Ports: i_clk, i_clr (sync clear), i_we/i_widx/i_wdata (write), i_ridx -> o_rdata (read, 0 if out of range)
module board_line_buf
    import tetris_board_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_clr,
    input  logic               i_we,
    input  logic [3:0]         i_widx,
    input  logic [COLOR_W-1:0] i_wdata,
    input  logic [3:0]         i_ridx,
    output logic [COLOR_W-1:0] o_rdata
);
    logic [COLOR_W-1:0] r_mem [COLS];

    always_ff @(posedge i_clk) begin
        if (i_clr) r_mem <= '{default: '0};
        else if (i_we && i_widx < 4'(COLS)) r_mem[i_widx] <= i_wdata;
    end

    assign o_rdata = i_ridx < 4'(COLS) ? r_mem[i_ridx] : '0;
endmodule

// File: rtl/board_fetch_arbiter.sv
// board_fetch_arbiter: shares the board RAM between per-row video prefetch and game-logic access
// Ports: Clk/Reset; DrawX/DrawY from VGA timing; gm_* game access handshake;
//        mem_* single-port sync RAM; cell_color/in_board registered pixel lookup
module board_fetch_arbiter
    import tetris_board_pkg::*;
#(
    parameter logic [9:0] BOARD_X0 = 10'd240,
    parameter logic [9:0] BOARD_Y0 = 10'd80
)(
    input  logic               Clk,
    input  logic               Reset,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               gm_req,
    input  logic               gm_we,
    input  logic [4:0]         gm_row,
    input  logic [3:0]         gm_col,
    input  logic [COLOR_W-1:0] gm_wdata,
    output logic               gm_ack,
    output logic [COLOR_W-1:0] gm_rdata,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic [COLOR_W-1:0] mem_rdata,
    output logic [COLOR_W-1:0] cell_color,
    output logic               in_board
);
    localparam logic [9:0] BOARD_W = 10'(COLS << CELL_SHIFT);
    localparam logic [9:0] BOARD_H = 10'(ROWS << CELL_SHIFT);
    localparam logic [9:0] H_BLANK = 10'd640;

    state_t             r_state;
    logic               r_pending;
    logic [3:0]         r_col_cnt;
    logic [4:0]         r_row;
    logic [9:0]         r_prev_x;
    logic               r_gm_rd;
    logic               r_in_board;
    logic [COLOR_W-1:0] r_cell_color;

    logic [9:0]         w_line;
    logic [9:0]         w_line_off;
    logic               w_trig;
    logic               w_fetch_go;
    logic               w_gm_go;
    logic               w_gm_ok;
    logic               w_fetching;
    logic               w_in_board;
    logic               w_buf_we;
    logic [3:0]         w_buf_widx;
    logic [3:0]         w_buf_ridx;
    logic [COLOR_W-1:0] w_buf_rdata;

    // The row about to be drawn is DrawY+1; fetch only at the start of each 16-line cell row.
    assign w_line     = DrawY + 10'd1;
    assign w_line_off = w_line - BOARD_Y0;
    assign w_trig     = DrawX == H_BLANK && r_prev_x != H_BLANK && w_line >= BOARD_Y0 &&
                        w_line < BOARD_Y0 + BOARD_H && w_line_off[3:0] == 4'd0;
    assign w_fetch_go = r_state == IDLE && (r_pending || w_trig);
    assign w_gm_ok    = gm_row < 5'(ROWS) && gm_col < 4'(COLS);
    assign w_gm_go    = !Reset && r_state == IDLE && !w_fetch_go && gm_req;
    assign w_fetching = !Reset && r_state == FETCH;
    assign w_in_board = DrawX >= BOARD_X0 && DrawX < BOARD_X0 + BOARD_W &&
                        DrawY >= BOARD_Y0 && DrawY < BOARD_Y0 + BOARD_H;

    assign mem_addr  = w_fetching ? cell_addr(r_row, r_col_cnt) :
                       w_gm_go && w_gm_ok ? cell_addr(gm_row, gm_col) : '0;
    assign mem_we    = w_gm_go && w_gm_ok && gm_we;
    assign mem_wdata = mem_we ? gm_wdata : '0;
    assign gm_ack    = !Reset && r_state == GAME_ACK;
    assign gm_rdata  = gm_ack && r_gm_rd ? mem_rdata : '0;

    // RAM data lags the address by one cycle, so FETCH col n stores column n-1.
    assign w_buf_we   = (r_state == FETCH && r_col_cnt != 4'd0) || r_state == FETCH_LAST;
    assign w_buf_widx = r_state == FETCH_LAST ? 4'(COLS - 1) : r_col_cnt - 4'd1;
    assign w_buf_ridx = 4'((DrawX - BOARD_X0) >> CELL_SHIFT);

    board_line_buf u_line_buf (
        .i_clk   (Clk),
        .i_clr   (Reset),
        .i_we    (w_buf_we),
        .i_widx  (w_buf_widx),
        .i_wdata (mem_rdata),
        .i_ridx  (w_buf_ridx),
        .o_rdata (w_buf_rdata)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_pending    <= 1'b0;
            r_col_cnt    <= '0;
            r_row        <= '0;
            r_prev_x     <= DrawX;
            r_gm_rd      <= 1'b0;
            r_in_board   <= 1'b0;
            r_cell_color <= '0;
        end else begin
            r_prev_x     <= DrawX;
            r_in_board   <= w_in_board;
            r_cell_color <= w_in_board ? w_buf_rdata : '0;
            r_pending    <= (r_pending || w_trig) && !w_fetch_go;
            if (w_trig) r_row <= 5'(w_line_off >> CELL_SHIFT);
            case (r_state)
                IDLE: begin
                    if (w_fetch_go) begin
                        r_state   <= FETCH;
                        r_col_cnt <= '0;
                    end else if (w_gm_go) begin
                        r_state <= GAME_ACK;
                        r_gm_rd <= !gm_we && w_gm_ok;
                    end
                end
                FETCH: begin
                    r_col_cnt <= r_col_cnt + 4'd1;
                    if (r_col_cnt == 4'(COLS - 1)) r_state <= FETCH_LAST;
                end
                FETCH_LAST: begin
                    r_state   <= IDLE;
                    r_col_cnt <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cell_color = r_cell_color;
    assign in_board   = r_in_board;
endmodule

// File: tb/tb_board_fetch_arbiter.sv
// tb_board_fetch_arbiter: directed stimulus with a gm_ack scoreboard and a sync RAM model
module tb_board_fetch_arbiter;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic       gm_req = 1'b0;
    logic       gm_we = 1'b0;
    logic [4:0] gm_row = '0;
    logic [3:0] gm_col = '0;
    logic [2:0] gm_wdata = '0;
    logic       gm_ack;
    logic [2:0] gm_rdata;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [2:0] mem_wdata;
    logic [2:0] mem_rdata;
    logic [2:0] cell_color;
    logic       in_board;

    logic       pre_we = 1'b0;
    logic [7:0] pre_addr = '0;
    logic [2:0] pre_data = '0;
    logic [2:0] ram  [256];
    logic [2:0] snap [256];
    logic [2:0] pat  [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2, 3'd3};
    logic [2:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    board_fetch_arbiter dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .gm_req     (gm_req),
        .gm_we      (gm_we),
        .gm_row     (gm_row),
        .gm_col     (gm_col),
        .gm_wdata   (gm_wdata),
        .gm_ack     (gm_ack),
        .gm_rdata   (gm_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .cell_color (cell_color),
        .in_board   (in_board)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic smp;
        @(negedge Clk);
    endtask

    always @(negedge Clk) begin
        if (gm_ack) begin
            if (exp_q.size() == 0) chk("gm_ack_unexpected", 1, 0);
            else chk("gm_rdata", int'(gm_rdata), int'(exp_q.pop_front()));
        end
    end

    task automatic line_edge(input int y);
        tick;
        DrawY = 10'(y);
        DrawX = 10'd639;
        tick;
        DrawX = 10'd640;
    endtask

    task automatic game(input logic we, input int row, input int col, input int wd);
        gm_req = 1'b1;
        gm_we = we;
        gm_row = 5'(row);
        gm_col = 4'(col);
        gm_wdata = 3'(wd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bx [6] = '{239, 240, 399, 400, 300, 300};
        int by [6] = '{100, 80, 399, 100, 79, 400};
        int bi [6] = '{0, 1, 1, 0, 0, 0};
        int ny [2] = '{399, 524};
        int d;
        pre_we = 1'b1;
        for (int i = 0; i < 256; i++) begin
            pre_addr = 8'(i);
            pre_data = (i >= 30 && i < 40) ? pat[i-30] : (i == 0 ? 3'd6 : 3'd0);
            tick;
        end
        pre_we = 1'b0;
        tick;
        Reset = 1'b0;
        smp;
        chk("rst_gm_ack", int'(gm_ack), 0);
        chk("rst_gm_rdata", int'(gm_rdata), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_cell_color", int'(cell_color), 0);
        chk("rst_in_board", int'(in_board), 0);

        tick;
        DrawX = 10'd300;
        DrawY = 10'd100;
        tick;
        smp;
        chk("empty_in_board", int'(in_board), 1);
        chk("empty_color", int'(cell_color), 0);
        for (int i = 0; i < 6; i++) begin
            tick;
            DrawX = 10'(bx[i]);
            DrawY = 10'(by[i]);
            tick;
            smp;
            chk($sformatf("bound_in_board_%0d", i), int'(in_board), bi[i]);
            chk($sformatf("bound_color_%0d", i), int'(cell_color), 0);
        end

        line_edge(127);
        smp;
        chk("fetch_c0_addr", int'(mem_addr), 0);
        for (int i = 0; i < 10; i++) begin
            tick;
            smp;
            chk($sformatf("fetch_addr_%0d", i), int'(mem_addr), 30 + i);
            chk($sformatf("fetch_we_%0d", i), int'(mem_we), 0);
        end
        tick;
        tick;
        DrawY = 10'd128;
        for (int x = 240; x < 400; x++) begin
            DrawX = 10'(x);
            tick;
            smp;
            chk($sformatf("pix_color_%0d", x), int'(cell_color), int'(pat[(x-240)/16]));
            chk($sformatf("pix_in_board_%0d", x), int'(in_board), 1);
            tick;
        end

        DrawX = 10'd100;
        DrawY = 10'd200;
        tick;
        game(1'b1, 19, 9, 5);
        exp_q.push_back(3'd0);
        smp;
        chk("wr_addr", int'(mem_addr), 199);
        chk("wr_we", int'(mem_we), 1);
        chk("wr_wdata", int'(mem_wdata), 5);
        chk("wr_ack_early", int'(gm_ack), 0);
        tick;
        gm_req = 1'b0;
        smp;
        chk("wr_ack", int'(gm_ack), 1);
        chk("wr_ack_we", int'(mem_we), 0);
        tick;
        game(1'b0, 19, 9, 0);
        exp_q.push_back(3'd5);
        smp;
        chk("rd_addr", int'(mem_addr), 199);
        chk("rd_we", int'(mem_we), 0);
        tick;
        gm_req = 1'b0;
        smp;
        chk("rd_ack", int'(gm_ack), 1);

        tick;
        game(1'b0, 3, 0, 0);
        exp_q.push_back(3'd1);
        smp;
        chk("b2b_addr0", int'(mem_addr), 30);
        tick;
        gm_col = 4'd1;
        exp_q.push_back(3'd2);
        smp;
        chk("b2b_ack0", int'(gm_ack), 1);
        chk("b2b_no_accept", int'(mem_addr), 0);
        tick;
        smp;
        chk("b2b_addr1", int'(mem_addr), 31);
        chk("b2b_gap", int'(gm_ack), 0);
        tick;
        gm_req = 1'b0;
        smp;
        chk("b2b_ack1", int'(gm_ack), 1);

        line_edge(127);
        game(1'b0, 3, 2, 0);
        exp_q.push_back(3'd3);
        smp;
        chk("cont_c0_addr", int'(mem_addr), 0);
        chk("cont_c0_ack", int'(gm_ack), 0);
        for (int c = 1; c <= 11; c++) begin
            tick;
            smp;
            chk($sformatf("cont_ack_c%0d", c), int'(gm_ack), 0);
            chk($sformatf("cont_addr_c%0d", c), int'(mem_addr), c <= 10 ? 29 + c : 0);
            chk($sformatf("cont_we_c%0d", c), int'(mem_we), 0);
        end
        tick;
        smp;
        chk("cont_c12_addr", int'(mem_addr), 32);
        chk("cont_c12_ack", int'(gm_ack), 0);
        tick;
        gm_req = 1'b0;
        smp;
        chk("cont_c13_ack", int'(gm_ack), 1);

        tick;
        DrawX = 10'd100;
        for (int i = 0; i < 256; i++) snap[i] = ram[i];
        game(1'b1, 20, 0, 7);
        exp_q.push_back(3'd0);
        smp;
        chk("oor_wr_we", int'(mem_we), 0);
        tick;
        gm_req = 1'b0;
        smp;
        chk("oor_wr_ack", int'(gm_ack), 1);
        chk("oor_wr_we_ack", int'(mem_we), 0);
        tick;
        tick;
        d = 0;
        for (int i = 0; i < 256; i++) if (ram[i] != snap[i]) d++;
        chk("oor_ram_unchanged", d, 0);
        game(1'b0, 5, 12, 0);
        exp_q.push_back(3'd0);
        tick;
        gm_req = 1'b0;
        smp;
        chk("oor_rd_ack", int'(gm_ack), 1);

        for (int i = 0; i < 2; i++) begin
            line_edge(ny[i]);
            for (int c = 1; c <= 3; c++) begin
                tick;
                smp;
                chk($sformatf("notrig_y%0d_c%0d", ny[i], c), int'(mem_addr), 0);
            end
            DrawX = 10'd100;
        end

        tick;
        game(1'b0, 19, 9, 0);
        tick;
        gm_req = 1'b0;
        Reset = 1'b1;
        smp;
        chk("rst_ack_abort", int'(gm_ack), 0);
        tick;
        Reset = 1'b0;
        smp;
        chk("rst_ack_after", int'(gm_ack), 0);

        line_edge(127);
        for (int c = 1; c <= 5; c++) tick;
        smp;
        chk("rstf_col4_addr", int'(mem_addr), 34);
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        smp;
        chk("rstf_addr", int'(mem_addr), 0);
        chk("rstf_we", int'(mem_we), 0);
        chk("rstf_ack", int'(gm_ack), 0);
        for (int c = 0; c < 12; c++) begin
            tick;
            smp;
            chk($sformatf("rstf_idle_addr_%0d", c), int'(mem_addr), 0);
        end
        tick;
        DrawY = 10'd128;
        for (int k = 0; k < 10; k++) begin
            DrawX = 10'(240 + 16 * k + 3);
            tick;
            smp;
            chk($sformatf("rstf_buf_%0d", k), int'(cell_color), 0);
            chk($sformatf("rstf_in_board_%0d", k), int'(in_board), 1);
            tick;
        end

        tick;
        chk("sb_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
